hazard_detection_unit: RTL and testbench
========================================

// Module: hazard_detection_unit
// PURPOSE
//   Stall/flush controller for the 5-stage RISC-V pipeline; complements the EX-stage forwarding logic.
//   Forwarding resolves dependencies whose result already exists. This block stalls or squashes when it does not:
//   - load-use: a load sits in ID/EX and the consumer sits in IF/ID;
//   - taken branch: resolved in EX;
//   - data-memory wait: dmem handshake not ready.
//   Drives the PC/IF-ID/ID-EX/EX-MEM register enables and keeps saturating stall statistics plus a sticky error flag.
// PARAMETERS
//   REG_ADDR_W  5   register index width
//   CNT_W       16  width of each statistics counter
//   MAX_WAIT    64  consecutive dmem wait cycles before hz_err sets (>=1)
// PORTS
//   clk            in   1          clock, rising edge
//   rst_n          in   1          reset, asynchronous, active-low
//   IFID_rs1       in   REG_ADDR_W source 1 of the instruction in ID
//   IFID_rs2       in   REG_ADDR_W source 2 of the instruction in ID
//   IFID_use_rs1   in   1          ID instruction actually reads rs1
//   IFID_use_rs2   in   1          ID instruction actually reads rs2
//   IDEX_rd        in   REG_ADDR_W destination of the instruction in EX
//   IDEX_MemRead   in   1          EX instruction is a load
//   branch_taken   in   1          EX resolved a taken branch/jump this cycle
//   dmem_req       in   1          MEM stage has an active data access
//   dmem_ready     in   1          data memory completes the access this cycle
//   cnt_clr        in   1          synchronous clear of counters and hz_err
//   PCWrite        out  1          PC update enable
//   IFID_Write     out  1          IF/ID register enable
//   IFID_Flush     out  1          IF/ID loads a NOP
//   IDEX_Hold      out  1          ID/EX holds its contents
//   IDEX_Bubble    out  1          ID/EX loads a NOP (control zeroed)
//   EXMEM_Hold     out  1          EX/MEM and MEM/WB hold
//   hz_state       out  2          FSM state: 00 RUN, 01 LOAD_STALL, 10 MEM_WAIT, 11 FLUSH
//   lu_cnt         out  CNT_W      load-use stall cycles
//   mw_cnt         out  CNT_W      dmem wait cycles
//   fl_cnt         out  CNT_W      branch flush events
//   hz_err         out  1          sticky protocol/timeout error
// BEHAVIOUR
//   Definitions:
//     lu = IDEX_MemRead & (IDEX_rd!=0) & ((IFID_use_rs1 & IDEX_rd==IFID_rs1) | (IFID_use_rs2 & IDEX_rd==IFID_rs2))
//     mw = dmem_req & ~dmem_ready
//   Enables are combinational from current inputs (0-cycle latency), priority mw > branch_taken > lu:
//     mw:            PCWrite=0 IFID_Write=0 IDEX_Hold=1 EXMEM_Hold=1 Flush=0 Bubble=0 (branch/lu ignored, EX frozen)
//     branch_taken:  PCWrite=1 IFID_Write=1 IFID_Flush=1 IDEX_Bubble=1 (lu ignored; wrong-path)
//     lu:            PCWrite=0 IFID_Write=0 IDEX_Bubble=1, all others 0
//     none:          PCWrite=1 IFID_Write=1, all others 0
//   Outputs while rst_n=0: PCWrite=0 IFID_Write=0 IFID_Flush=1 IDEX_Bubble=1 IDEX_Hold=0 EXMEM_Hold=0.
//   FSM, registered: next state = MEM_WAIT if mw, else FLUSH if branch_taken, else LOAD_STALL if lu, else RUN.
//   hz_state therefore reports the action taken in the previous cycle.
//   wait_cnt (internal, ceil(log2(MAX_WAIT+1)) bits): increments on each mw cycle, cleared on any non-mw cycle.
//   hz_err sets at the edge that ends the MAX_WAIT-th consecutive mw cycle (wait_cnt==MAX_WAIT-1 & mw).
//   hz_err also sets if lu occurs while hz_state==LOAD_STALL (bubble failed to clear the load).
//   hz_err is sticky until cnt_clr or reset.
//   Counters: lu_cnt +1 on each lu-action cycle; mw_cnt +1 on each mw cycle; fl_cnt +1 on each branch-flush cycle.
//   Counters saturate at all-ones, never wrap. cnt_clr wins over increment in the same cycle.
//   Reset values: hz_state=RUN, all counters 0, wait_cnt 0, hz_err 0.
//   Reset asserted mid-MEM_WAIT aborts immediately: no hz_err, wait_cnt=0.
// TESTING
//   1. lw x5 in EX, add x6,x5,x1 in ID (use_rs1=1) -> 1 cycle PCWrite=0/IDEX_Bubble=1, then RUN; lu_cnt=1.
//   2. IDEX_rd=0 load, or use_rs2=0 with rs2 match -> no stall, PCWrite=1.
//   3. branch_taken with lu also true -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1; fl_cnt=1, lu_cnt=0.
//   4. dmem_req=1, dmem_ready=0 for 3 cycles, then ready -> all holds for 3 cycles; mw_cnt=3; hz_err=0.
//   5. MAX_WAIT=4, 4 wait cycles -> hz_err=1 after 4th edge; cnt_clr -> hz_err=0, counters 0.
//   6. rst_n low during MEM_WAIT -> hz_state=RUN, safe outputs asynchronously; lu_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for a 5-stage RISC-V pipeline: load-use, taken-branch and dmem-wait hazards,
// with saturating stall statistics and a sticky error flag.
module hazard_detection_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16,
  parameter int MAX_WAIT   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] IFID_rs1,
  input  logic [REG_ADDR_W-1:0] IFID_rs2,
  input  logic                  IFID_use_rs1,
  input  logic                  IFID_use_rs2,
  input  logic [REG_ADDR_W-1:0] IDEX_rd,
  input  logic                  IDEX_MemRead,
  input  logic                  branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  input  logic                  cnt_clr,
  output logic                  PCWrite,
  output logic                  IFID_Write,
  output logic                  IFID_Flush,
  output logic                  IDEX_Hold,
  output logic                  IDEX_Bubble,
  output logic                  EXMEM_Hold,
  output logic [1:0]            hz_state,
  output logic [CNT_W-1:0]      lu_cnt,
  output logic [CNT_W-1:0]      mw_cnt,
  output logic [CNT_W-1:0]      fl_cnt,
  output logic                  hz_err
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_TRIP = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_LOAD_STALL = 2'b01,
    ST_MEM_WAIT   = 2'b10,
    ST_FLUSH      = 2'b11
  } hz_state_e;

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]  mw_cnt_q, mw_cnt_d;
  logic [CNT_W-1:0]  fl_cnt_q, fl_cnt_d;
  logic              hz_err_q, hz_err_d;

  logic lu, mw, fl_act, lu_act, err_set;

  always_comb begin
    lu = IDEX_MemRead && (IDEX_rd != '0) &&
         ((IFID_use_rs1 && (IDEX_rd == IFID_rs1)) || (IFID_use_rs2 && (IDEX_rd == IFID_rs2)));
    mw     = dmem_req && !dmem_ready;
    fl_act = branch_taken && !mw;
    lu_act = lu && !mw && !branch_taken;
  end

  // Enables follow current inputs; reset forces a NOP into IF/ID and ID/EX.
  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Hold   = 1'b0;
    IDEX_Bubble = 1'b0;
    EXMEM_Hold  = 1'b0;
    if (!rst_n) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (mw) begin
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Hold  = 1'b1;
      EXMEM_Hold = 1'b1;
    end else if (branch_taken) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (lu) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end
  end

  always_comb begin
    state_d    = ST_RUN;
    wait_cnt_d = '0;
    lu_cnt_d   = lu_cnt_q;
    mw_cnt_d   = mw_cnt_q;
    fl_cnt_d   = fl_cnt_q;
    if (mw)          state_d = ST_MEM_WAIT;
    else if (branch_taken) state_d = ST_FLUSH;
    else if (lu)     state_d = ST_LOAD_STALL;

    // Saturate so a stuck memory cannot wrap the counter and re-arm the timeout.
    if (mw) wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);

    // A repeated load-use right after a bubble means the load never left ID/EX.
    err_set  = (mw && (wait_cnt_q == WAIT_TRIP)) || (lu && (state_q == ST_LOAD_STALL));
    hz_err_d = hz_err_q || err_set;

    if (lu_act && (lu_cnt_q != CNT_MAX)) lu_cnt_d = lu_cnt_q + CNT_W'(1);
    if (mw     && (mw_cnt_q != CNT_MAX)) mw_cnt_d = mw_cnt_q + CNT_W'(1);
    if (fl_act && (fl_cnt_q != CNT_MAX)) fl_cnt_d = fl_cnt_q + CNT_W'(1);

    if (cnt_clr) begin
      lu_cnt_d = '0;
      mw_cnt_d = '0;
      fl_cnt_d = '0;
      hz_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      lu_cnt_q   <= '0;
      mw_cnt_q   <= '0;
      fl_cnt_q   <= '0;
      hz_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lu_cnt_q   <= lu_cnt_d;
      mw_cnt_q   <= mw_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
      hz_err_q   <= hz_err_d;
    end
  end

  assign hz_state = state_q;
  assign lu_cnt   = lu_cnt_q;
  assign mw_cnt   = mw_cnt_q;
  assign fl_cnt   = fl_cnt_q;
  assign hz_err   = hz_err_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Randomized + directed bench for hazard_detection_unit; a driver pushes expected responses from a
// behavioural model into a queue and a negedge monitor pops and compares.
module tb_hazard_detection_unit;

  localparam int RW = 5;
  localparam int CW = 10;
  localparam int MW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [RW-1:0] IFID_rs1 = '0, IFID_rs2 = '0, IDEX_rd = '0;
  logic IFID_use_rs1 = 0, IFID_use_rs2 = 0, IDEX_MemRead = 0, branch_taken = 0;
  logic dmem_req = 0, dmem_ready = 0, cnt_clr = 0;
  logic PCWrite, IFID_Write, IFID_Flush, IDEX_Hold, IDEX_Bubble, EXMEM_Hold, hz_err;
  logic [1:0] hz_state;
  logic [CW-1:0] lu_cnt, mw_cnt, fl_cnt;

  hazard_detection_unit #(.REG_ADDR_W(RW), .CNT_W(CW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
    .IFID_use_rs1(IFID_use_rs1), .IFID_use_rs2(IFID_use_rs2),
    .IDEX_rd(IDEX_rd), .IDEX_MemRead(IDEX_MemRead), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Hold(IDEX_Hold), .IDEX_Bubble(IDEX_Bubble), .EXMEM_Hold(EXMEM_Hold),
    .hz_state(hz_state), .lu_cnt(lu_cnt), .mw_cnt(mw_cnt), .fl_cnt(fl_cnt), .hz_err(hz_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] en;   // {PCWrite, IFID_Write, IFID_Flush, IDEX_Hold, IDEX_Bubble, EXMEM_Hold}
    int st, lu, mw, fl;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Reference model state: what happened last cycle, consecutive waits, statistics.
  int m_last = 0;   // 0 none, 1 load-use, 2 mem wait, 3 flush
  int m_wait = 0;
  int m_lu = 0, m_mw = 0, m_fl = 0;
  bit m_err = 0;

  task automatic step(input bit r, input int a1, input int a2, input bit u1, input bit u2,
                      input int rd, input bit mr, input bit br, input bit rq, input bit ry,
                      input bit cl);
    exp_t e;
    bit lu, mw;
    int act;
    @(posedge clk);
    #1;
    rst_n = r;
    IFID_rs1 = RW'(a1); IFID_rs2 = RW'(a2);
    IFID_use_rs1 = u1; IFID_use_rs2 = u2;
    IDEX_rd = RW'(rd); IDEX_MemRead = mr; branch_taken = br;
    dmem_req = rq; dmem_ready = ry; cnt_clr = cl;
    lu = mr && rd != 0 && ((u1 && rd == a1) || (u2 && rd == a2));
    mw = rq && !ry;
    act = mw ? 2 : br ? 3 : lu ? 1 : 0;
    if (!r) begin
      m_last = 0; m_wait = 0; m_lu = 0; m_mw = 0; m_fl = 0; m_err = 0;
    end
    case (r ? act : -1)
      -1: e.en = 6'b001010;
      2:  e.en = 6'b000101;
      3:  e.en = 6'b111010;
      1:  e.en = 6'b000010;
      default: e.en = 6'b110000;
    endcase
    e.st = m_last; e.lu = m_lu; e.mw = m_mw; e.fl = m_fl; e.err = m_err;
    exp_q.push_back(e);
    if (r) begin
      bit set_err;
      set_err = (mw && m_wait + 1 == MW) || (lu && m_last == 1);
      if (cl) begin
        m_lu = 0; m_mw = 0; m_fl = 0; m_err = 0;
      end else begin
        if (act == 1) m_lu = (m_lu < CMAX) ? m_lu + 1 : CMAX;
        if (act == 2) m_mw = (m_mw < CMAX) ? m_mw + 1 : CMAX;
        if (act == 3) m_fl = (m_fl < CMAX) ? m_fl + 1 : CMAX;
        m_err = m_err | set_err;
      end
      m_wait = mw ? m_wait + 1 : 0;
      m_last = act;
    end
  endtask

  task automatic idle(input bit cl);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, cl);
  endtask

  task automatic chk(input string name, input int act_v, input int exp_v);
    total++;
    if (act_v != exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act_v, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("enables", int'({PCWrite, IFID_Write, IFID_Flush, IDEX_Hold, IDEX_Bubble, EXMEM_Hold}),
            int'(e.en));
        chk("hz_state", int'(hz_state), e.st);
        chk("lu_cnt", int'(lu_cnt), e.lu);
        chk("mw_cnt", int'(mw_cnt), e.mw);
        chk("fl_cnt", int'(fl_cnt), e.fl);
        chk("hz_err", int'(hz_err), int'(e.err));
      end
    end
  end

  initial begin : driver
    int guard;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    // load-use: lw x5 / add x6,x5,x1
    step(1, 5, 1, 1, 1, 5, 1, 0, 0, 0, 0);
    idle(0);
    // no stall: rd=x0 load, and rs2 match with use_rs2=0
    step(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    step(1, 1, 7, 1, 0, 7, 1, 0, 0, 0, 0);
    // branch wins over load-use
    step(1, 5, 1, 1, 1, 5, 1, 1, 0, 0, 0);
    idle(0);
    // three dmem waits then ready
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(0);
    // MAX_WAIT consecutive waits raise hz_err; cnt_clr clears it
    repeat (MW) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(0);
    idle(1);
    idle(0);
    // MAX_WAIT-1 waits must not raise hz_err
    repeat (MW - 1) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(0);
    // reset in the middle of a wait
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 149) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 5) == 0,
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 49) == 0);
    end
    // load-use counter saturation
    idle(1);
    for (int i = 0; i < CMAX + 20; i++) step(1, 3, 0, 1, 0, 3, 1, 0, 0, 0, 0);
    idle(0);
    idle(0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
